huffman_ac_decode_ctrl: RTL

Sequencer that drives the AC Huffman lookup table, one bit at a time, during JPEG-style entropy decoding. It takes a serial bitstream, grows the candidate code, and issues one LUT lookup per bit. On a match it collects the amplitude bits and emits a (run, size, amplitude) symbol. It also tracks the coefficient index within an 8x8 block, reports EOB/ZRL/block completion, and flags illegal codes. It sits between the bit unpacker and the dequant/zigzag stage.

---
 rtl/huffman_ac_decode_ctrl_if.sv | 46 ++++
 rtl/huffman_ac_decode_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/huffman_ac_decode_ctrl_if.sv
// Bus bundle for the AC Huffman decode controller.
//   bit stream : bit_in, bit_valid_in -> controller; bit_ready_out <- controller
//   LUT        : lut_code_out, lut_code_len_out, lut_enable_out <- controller
//                lut_valid_in, lut_codesize_in, lut_size_in, lut_run_in -> controller
//   symbol     : sym_valid_out, run_out, size_out, amp_out, coef_idx_out, eob_out,
//                block_done_out, err_out <- controller; sym_ready_in -> controller
// modport master is the controller, modport slave is its environment.
interface huffman_ac_decode_ctrl_if #(
   parameter int AMP_W = 11
);
   logic             bit_in;
   logic             bit_valid_in;
   logic             bit_ready_out;
   logic [15:0]      lut_code_out;
   logic [4:0]       lut_code_len_out;
   logic             lut_enable_out;
   logic             lut_valid_in;
   logic [4:0]       lut_codesize_in;
   logic [4:0]       lut_size_in;
   logic [4:0]       lut_run_in;
   logic             sym_valid_out;
   logic             sym_ready_in;
   logic [3:0]       run_out;
   logic [3:0]       size_out;
   logic [AMP_W-1:0] amp_out;
   logic [5:0]       coef_idx_out;
   logic             eob_out;
   logic             block_done_out;
   logic             err_out;

   modport master (
      input  bit_in, bit_valid_in, lut_valid_in, lut_codesize_in, lut_size_in,
             lut_run_in, sym_ready_in,
      output bit_ready_out, lut_code_out, lut_code_len_out, lut_enable_out,
             sym_valid_out, run_out, size_out, amp_out, coef_idx_out, eob_out,
             block_done_out, err_out
   );

   modport slave (
      output bit_in, bit_valid_in, lut_valid_in, lut_codesize_in, lut_size_in,
             lut_run_in, sym_ready_in,
      input  bit_ready_out, lut_code_out, lut_code_len_out, lut_enable_out,
             sym_valid_out, run_out, size_out, amp_out, coef_idx_out, eob_out,
             block_done_out, err_out
   );
endinterface

// File: rtl/huffman_ac_decode_ctrl.sv
// AC Huffman decode sequencer: grows a candidate code one bit at a time,
// queries an external LUT (one-cycle latency) per bit, collects amplitude
// bits on a match and emits (run, size, amplitude) symbols with the
// coefficient index inside the 8x8 block.
//   clk_in  : system clock
//   rst_in  : asynchronous active-low reset
//   bus     : huffman_ac_decode_ctrl_if.master (bit stream, LUT, symbol)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | one cycle after reset
// S_SHIFT  | accept next code bit
// S_LOOKUP | LUT read of the current candidate code
// S_CHECK  | LUT result available, decide match / grow / error
// S_AMP    | accept `size` amplitude bits
// S_EMIT   | present symbol until sym_ready_in
// S_ERROR  | illegal code or index overflow, left only by reset
module huffman_ac_decode_ctrl #(
   parameter int MAX_CODE_LEN = 16,
   parameter int AMP_W        = 11,
   parameter int LAST_COEF    = 63
) (
   input logic                      clk_in,
   input logic                      rst_in,
   huffman_ac_decode_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_SHIFT, S_LOOKUP, S_CHECK, S_AMP, S_EMIT, S_ERROR
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      code_q, code_d;
   logic [4:0]       len_q, len_d;
   logic [6:0]       idx_q, idx_d;
   logic [3:0]       run_q, run_d;
   logic [3:0]       size_q, size_d;
   logic [3:0]       amp_cnt_q, amp_cnt_d;
   logic [AMP_W-1:0] amp_q, amp_d;
   logic             err_q, err_d;

   logic [6:0] coef_sum;
   logic       overflow, is_eob, is_zrl, lut_hit, lut_bad;

   // 7-bit sum so an index past LAST_COEF is visible instead of wrapping
   assign coef_sum = idx_q + {3'd0, run_q};
   assign overflow = coef_sum > 7'(LAST_COEF);
   assign is_eob   = (run_q == 4'd0) && (size_q == 4'd0);
   assign is_zrl   = (run_q == 4'd15) && (size_q == 4'd0);
   assign lut_hit  = bus.lut_valid_in && (bus.lut_codesize_in == len_q);
   // a matched entry whose run or size cannot be represented is treated as illegal
   assign lut_bad  = bus.lut_run_in[4] || (bus.lut_size_in > 5'(AMP_W));

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q   <= S_IDLE;
         code_q    <= '0;
         len_q     <= '0;
         idx_q     <= 7'd1;
         run_q     <= '0;
         size_q    <= '0;
         amp_cnt_q <= '0;
         amp_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         code_q    <= code_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         run_q     <= run_d;
         size_q    <= size_d;
         amp_cnt_q <= amp_cnt_d;
         amp_q     <= amp_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      len_d     = len_q;
      idx_d     = idx_q;
      run_d     = run_q;
      size_d    = size_q;
      amp_cnt_d = amp_cnt_q;
      amp_d     = amp_q;
      err_d     = err_q;

      bus.bit_ready_out    = 1'b0;
      bus.lut_code_out     = '0;
      bus.lut_code_len_out = '0;
      bus.lut_enable_out   = 1'b0;
      bus.sym_valid_out    = 1'b0;
      bus.run_out          = '0;
      bus.size_out         = '0;
      bus.amp_out          = '0;
      bus.coef_idx_out     = '0;
      bus.eob_out          = 1'b0;
      bus.block_done_out   = 1'b0;
      bus.err_out          = err_q;

      case (state_q)
         S_IDLE: state_d = S_SHIFT;
         S_SHIFT: begin
            bus.bit_ready_out = 1'b1;
            if (bus.bit_valid_in) begin
               code_d  = {code_q[14:0], bus.bit_in};
               len_d   = len_q + 5'd1;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            bus.lut_enable_out   = 1'b1;
            bus.lut_code_out     = code_q;
            bus.lut_code_len_out = len_q;
            state_d              = S_CHECK;
         end
         S_CHECK: begin
            if (lut_hit && lut_bad) begin
               err_d   = 1'b1;
               state_d = S_ERROR;
            end else if (lut_hit) begin
               run_d     = bus.lut_run_in[3:0];
               size_d    = bus.lut_size_in[3:0];
               code_d    = '0;
               len_d     = '0;
               amp_d     = '0;
               amp_cnt_d = '0;
               state_d   = (bus.lut_size_in == 5'd0) ? S_EMIT : S_AMP;
            end else if (len_q < 5'(MAX_CODE_LEN)) begin
               state_d = S_SHIFT;
            end else begin
               err_d   = 1'b1;
               state_d = S_ERROR;
            end
         end
         S_AMP: begin
            bus.bit_ready_out = 1'b1;
            if (bus.bit_valid_in) begin
               amp_d     = {amp_q[AMP_W-2:0], bus.bit_in};
               amp_cnt_d = amp_cnt_q + 4'd1;
               if (amp_cnt_q + 4'd1 == size_q) state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            if (overflow) begin
               err_d   = 1'b1;
               state_d = S_ERROR;
            end else begin
               bus.sym_valid_out = 1'b1;
               bus.run_out       = run_q;
               bus.size_out      = size_q;
               bus.amp_out       = amp_q;
               bus.coef_idx_out  = coef_sum[5:0];
               bus.eob_out       = is_eob;
               if (bus.sym_ready_in) begin
                  if (is_eob || (coef_sum == 7'(LAST_COEF) && size_q != 4'd0)) begin
                     bus.block_done_out = 1'b1;
                     idx_d              = 7'd1;
                  end else if (is_zrl) begin
                     idx_d = idx_q + 7'd16;
                  end else begin
                     idx_d = coef_sum + 7'd1;
                  end
                  state_d = S_SHIFT;
               end
            end
         end
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_ERROR;
      endcase
   end
endmodule
